link_tx: RTL and testbench
==========================

# link_tx

Credit-based link transmitter that drives one router output port onto its MGT lane. It is the sending end of the input-queue protocol: it tracks free slots in the downstream router's input queue and merges flits from the switch output and the local injection port. It also emits credit flits that return freed slots of this router's own input queue to the upstream neighbour. One instance sits per port between the switch/inject mux and the MGT TX.

## Interface
- FLIT_SIZE, 82, flit width; bit FLIT_SIZE-1 = valid, bit FLIT_SIZE-2 = credit-type flag
- CREDIT_INIT, 5, downstream input-queue depth (initial credits)
- CREDIT_W, 8, width of credit counters and credit-flit count field
- CREDIT_PERIOD, 100, max cycles between credit flits while credits are pending
- CREDIT_THRESH, 4, pending-credit count that forces an immediate credit flit
- MAX_INJ_BURST, 4, consecutive inject grants before the switch gets one slot
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- sw_flit  in  FLIT_SIZE  flit from switch output
- sw_valid  in  1  sw_flit valid
- sw_ready  out  1  sw_flit accepted this cycle
- inj_flit  in  FLIT_SIZE  flit from application kernel
- inj_valid  in  1  inj_flit valid
- inj_ready  out  1  inj_flit accepted this cycle
- credit_in  in  CREDIT_W  credits returned by downstream (from RX credit flit)
- credit_in_valid  in  1  credit_in valid
- rx_consume  in  1  one slot freed in this router's input queue
- out_flit  out  FLIT_SIZE  to MGT
- out_valid  out  1  out_flit valid
- credits  out  CREDIT_W  current downstream credit count
- credit_overflow  out  1  sticky: credits would exceed CREDIT_INIT

## Operation
- Transfer occurs on valid && ready in the same cycle; ready is combinational from valid, credits and arbiter state.
- Per cycle, at most one flit is sent. Priority: pending credit flit, then data.
- Credit flit due when pend >= CREDIT_THRESH, or when timer == CREDIT_PERIOD-1 and pend > 0.
- Credit flit format: valid=1, credit flag=1, bits [CREDIT_W-1:0] = pend, rest 0. It does not consume downstream credits.
- Data is granted only if credits > 0 and no credit flit is due.
- Inject has priority over switch. After MAX_INJ_BURST consecutive inject grants with sw_valid high, the next grant goes to the switch.
- The burst counter clears on any switch grant or on any cycle with inj_valid low.
- Data flits are sent with the credit flag forced to 0.
- credits update: next = credits − (data sent) + (credit_in_valid ? credit_in : 0).
- If next > CREDIT_INIT: clamp to CREDIT_INIT and set credit_overflow.
- pend: +1 per rx_consume, saturating at 2^CREDIT_W−1.
- On emit, pend resets to rx_consume of that cycle (0 or 1) and timer resets to 0. Otherwise the timer increments while pend > 0 and holds at 0 when pend == 0.

## Timing
- Reset values: out_flit=0, out_valid=0, credits=CREDIT_INIT, pend=0, timer=0, burst=0, credit_overflow=0. sw_ready/inj_ready are 0 during reset.
- out_flit/out_valid are registered; latency is 1 cycle from accept to output.
- When nothing is sent, out_valid=0 and out_flit=0.
- A credit_in in cycle N is usable for a grant in cycle N+1.
- If credits==1 and a data send coincides with credit_in=k, the result is k credits.
- Reset mid-operation discards any in-flight pend, and the downstream peer must be reset together.
- No backpressure from MGT; out_valid is never stalled.

## Configuration
- CREDIT_RETURN_EN defined: credit-flit generator present as described.
- CREDIT_RETURN_EN undefined: rx_consume ignored, no credit flits are ever emitted, and data arbitration ignores the credit-due condition. Downstream credit tracking is unchanged.

## Structure
- Shared package noc_link_pkg holds:
  - FLIT_SIZE, VALID_BIT, CREDIT_BIT constants
  - flit typedef
  - function build_credit_flit(count)
- The router RX side uses the same package to decode credit flits.
- One sub-module: credit_return_gen (pend counter, period timer, due flag, credit flit build). It is instantiated only under CREDIT_RETURN_EN.

## Test plan
- Reset, then sw_valid held for 7 cycles with no credit_in: 5 flits sent on consecutive cycles, then sw_ready=0 and credits=0.
- credits=0, then credit_in=3 valid: next cycle sends resume, and exactly 3 flits go out.
- inj_valid and sw_valid held continuously: grant pattern is I,I,I,I,S repeating, out_valid high every cycle.
- 4 rx_consume pulses: a credit flit with count 4 appears the cycle after pend reaches 4, pre-empting a ready data flit.
- One rx_consume then idle: a credit flit with count 1 appears at cycle 100 after the pulse.
- credits=5, then credit_in=1: credits stays 5 and credit_overflow=1 until reset.

Source files
------------

// File: rtl/noc_link_pkg.sv
// noc_link_pkg: link-level constants, flit layout and credit-flit builder shared
// by the link transmitter and the router RX side (which decodes credit flits).
// No ports; import with noc_link_pkg::*.
package noc_link_pkg;

   localparam int unsigned FLIT_SIZE     = 82;
   localparam int unsigned VALID_BIT     = FLIT_SIZE - 1;
   localparam int unsigned CREDIT_BIT    = FLIT_SIZE - 2;
   localparam int unsigned CREDIT_W      = 8;
   localparam int unsigned CREDIT_INIT   = 5;
   localparam int unsigned CREDIT_PERIOD = 100;
   localparam int unsigned CREDIT_THRESH = 4;
   localparam int unsigned MAX_INJ_BURST = 4;
   localparam int unsigned TIMER_W       = $clog2(CREDIT_PERIOD);
   localparam int unsigned BURST_W       = $clog2(MAX_INJ_BURST + 1);
   localparam int unsigned PAYLOAD_W     = FLIT_SIZE - 2;

   // Field order matches VALID_BIT / CREDIT_BIT positions.
   typedef struct packed {
      logic                 valid;
      logic                 credit;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;

   // Credit flit: valid=1, credit flag=1, count in the low CREDIT_W bits, rest 0.
   function automatic flit_t build_credit_flit(input logic [CREDIT_W-1:0] count);
      flit_t f;
      f         = '0;
      f.valid   = 1'b1;
      f.credit  = 1'b1;
      f.payload = PAYLOAD_W'(count);
      return f;
   endfunction

endpackage

// File: rtl/credit_return_gen.sv
// credit_return_gen: counts slots freed in this router's input queue and decides
// when a credit flit returning them to the upstream neighbour is due.
// Ports: clk, rst (async, active-high), consume (one slot freed),
//        due_c (credit flit must be sent this cycle), credit_flit_c (flit to send).
// A due credit flit is always emitted by the parent, so due_c doubles as emit.
module credit_return_gen
   import noc_link_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  consume,
   output logic  due_c,
   output flit_t credit_flit_c
);

   localparam logic [CREDIT_W-1:0] PEND_MAX = '1;

   logic [CREDIT_W-1:0] pend;
   logic [TIMER_W-1:0]  timer;

   assign due_c = (pend >= CREDIT_W'(CREDIT_THRESH)) ||
                  ((timer == TIMER_W'(CREDIT_PERIOD - 1)) && (pend != '0));
   assign credit_flit_c = build_credit_flit(pend);

   // Pending-credit counter and period timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend  <= '0;
         timer <= '0;
      end else if (due_c) begin
         // A slot freed in the emit cycle is not in this flit; carry it over.
         pend  <= CREDIT_W'(consume);
         timer <= '0;
      end else begin
         if (consume && (pend != PEND_MAX))
            pend <= pend + CREDIT_W'(1);
         timer <= (pend != '0) ? timer + TIMER_W'(1) : '0;
      end
   end

endmodule

// File: rtl/link_tx.sv
// link_tx: credit-based link transmitter for one router output port.
// Merges switch and inject flits toward the MGT lane under downstream credit
// control, and (when CREDIT_RETURN_EN is defined) interleaves credit flits that
// return freed input-queue slots to the upstream neighbour.
// Ports: clk, rst (async, active-high); sw_flit/sw_valid/sw_ready and
//        inj_flit/inj_valid/inj_ready (accept on valid && ready, ready is
//        combinational); credit_in/credit_in_valid (credits from downstream);
//        rx_consume (local slot freed); out_flit/out_valid (registered, to MGT);
//        credits (downstream credit count); credit_overflow (sticky).
// Macro CREDIT_RETURN_EN: enables the credit-flit generator; otherwise
//        rx_consume is ignored and no credit flits are sent.
module link_tx
   import noc_link_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [FLIT_SIZE-1:0] sw_flit,
   input  logic                 sw_valid,
   output logic                 sw_ready,
   input  logic [FLIT_SIZE-1:0] inj_flit,
   input  logic                 inj_valid,
   output logic                 inj_ready,
   input  logic [CREDIT_W-1:0]  credit_in,
   input  logic                 credit_in_valid,
   input  logic                 rx_consume,
   output logic [FLIT_SIZE-1:0] out_flit,
   output logic                 out_valid,
   output logic [CREDIT_W-1:0]  credits,
   output logic                 credit_overflow
);

   localparam int unsigned SUM_W = CREDIT_W + 1;

   logic                due_c;
   flit_t               credit_flit_c;
   logic [BURST_W-1:0]  burst;
   logic                data_ok_c;
   logic                sw_turn_c;
   logic                inj_grant_c;
   logic                sw_grant_c;
   flit_t               data_flit_c;
   logic [SUM_W-1:0]    credit_sum_c;
   logic                overflow_c;
   logic [CREDIT_W-1:0] credit_next_c;

`ifdef CREDIT_RETURN_EN
   credit_return_gen u_credit_return_gen (
      .clk           (clk),
      .rst           (rst),
      .consume       (rx_consume),
      .due_c         (due_c),
      .credit_flit_c (credit_flit_c)
   );
`else
   logic unused_rx_consume;
   assign unused_rx_consume = rx_consume;
   assign due_c             = 1'b0;
   assign credit_flit_c     = '0;
`endif

   // Arbitration, outgoing data flit and next credit count.
   always_comb begin
      data_ok_c   = !rst && (credits != '0) && !due_c;
      // Switch gets one slot once the inject burst limit is reached.
      sw_turn_c   = sw_valid && (burst == BURST_W'(MAX_INJ_BURST));
      inj_grant_c = data_ok_c && inj_valid && !sw_turn_c;
      sw_grant_c  = data_ok_c && sw_valid && !inj_grant_c;

      data_flit_c        = flit_t'(inj_grant_c ? inj_flit : sw_flit);
      data_flit_c.valid  = 1'b1;
      data_flit_c.credit = 1'b0;

      credit_sum_c  = SUM_W'(credits) - SUM_W'(inj_grant_c || sw_grant_c)
                    + (credit_in_valid ? SUM_W'(credit_in) : SUM_W'(0));
      overflow_c    = credit_sum_c > SUM_W'(CREDIT_INIT);
      credit_next_c = overflow_c ? CREDIT_W'(CREDIT_INIT) : credit_sum_c[CREDIT_W-1:0];
   end

   assign sw_ready  = sw_grant_c;
   assign inj_ready = inj_grant_c;

   // Output register, credit tracking and inject-burst counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_flit        <= '0;
         out_valid       <= 1'b0;
         credits         <= CREDIT_W'(CREDIT_INIT);
         credit_overflow <= 1'b0;
         burst           <= '0;
      end else begin
         credits <= credit_next_c;
         if (overflow_c)
            credit_overflow <= 1'b1;

         if (sw_grant_c || !inj_valid)
            burst <= '0;
         else if (inj_grant_c && (burst != BURST_W'(MAX_INJ_BURST)))
            burst <= burst + BURST_W'(1);

         if (due_c) begin
            out_flit  <= credit_flit_c;
            out_valid <= 1'b1;
         end else if (inj_grant_c || sw_grant_c) begin
            out_flit  <= data_flit_c;
            out_valid <= 1'b1;
         end else begin
            out_flit  <= '0;
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_link_tx.sv
// tb_link_tx: directed scoreboard bench for link_tx. The driver pushes each
// expected output flit when it issues the accepting cycle; a negedge monitor
// pops and compares whenever out_valid is high and checks idle cycles are zero.
`timescale 1ns/1ps
module tb_link_tx;
   import noc_link_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [FLIT_SIZE-1:0] sw_flit;
   logic                 sw_valid;
   logic                 sw_ready;
   logic [FLIT_SIZE-1:0] inj_flit;
   logic                 inj_valid;
   logic                 inj_ready;
   logic [CREDIT_W-1:0]  credit_in;
   logic                 credit_in_valid;
   logic                 rx_consume;
   logic [FLIT_SIZE-1:0] out_flit;
   logic                 out_valid;
   logic [CREDIT_W-1:0]  credits;
   logic                 credit_overflow;

   int total = 0;
   int bad   = 0;
   logic [FLIT_SIZE-1:0] exp_q[$];
   logic [15:0] sc;
   logic [15:0] ic;

   link_tx dut (
      .clk             (clk),
      .rst             (rst),
      .sw_flit         (sw_flit),
      .sw_valid        (sw_valid),
      .sw_ready        (sw_ready),
      .inj_flit        (inj_flit),
      .inj_valid       (inj_valid),
      .inj_ready       (inj_ready),
      .credit_in       (credit_in),
      .credit_in_valid (credit_in_valid),
      .rx_consume      (rx_consume),
      .out_flit        (out_flit),
      .out_valid       (out_valid),
      .credits         (credits),
      .credit_overflow (credit_overflow)
   );

   always #5 clk = ~clk;

   // Input flits carry a set credit flag that the DUT must clear.
   function automatic logic [FLIT_SIZE-1:0] in_flit(input logic [15:0] tag);
      logic [FLIT_SIZE-1:0] f;
      f = '0;
      f[FLIT_SIZE-1] = 1'b1;
      f[FLIT_SIZE-2] = 1'b1;
      f[60] = 1'b1;
      f[15:0] = tag;
      return f;
   endfunction

   function automatic logic [FLIT_SIZE-1:0] exp_data(input logic [15:0] tag);
      logic [FLIT_SIZE-1:0] f;
      f = '0;
      f[FLIT_SIZE-1] = 1'b1;
      f[60] = 1'b1;
      f[15:0] = tag;
      return f;
   endfunction

   function automatic logic [FLIT_SIZE-1:0] exp_credit(input logic [7:0] count);
      logic [FLIT_SIZE-1:0] f;
      f = '0;
      f[FLIT_SIZE-1] = 1'b1;
      f[FLIT_SIZE-2] = 1'b1;
      f[7:0] = count;
      return f;
   endfunction

   task automatic chk(input string name, input logic [FLIT_SIZE-1:0] act,
                      input logic [FLIT_SIZE-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop and compare on every output flit; idle cycles must be zero.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got %h want none", out_flit);
            end else begin
               chk("out_flit", out_flit, exp_q.pop_front());
            end
         end else begin
            chk("idle_zero", out_flit, '0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      sw_valid = 1'b1;
      inj_valid = 1'b1;
      sw_flit = in_flit(16'h5000);
      inj_flit = in_flit(16'h1000);
      credit_in = '0;
      credit_in_valid = 1'b0;
      rx_consume = 1'b0;
      sc = 16'd0;
      ic = 16'd0;
      #2;
      chkv("rst_sw_ready", int'(sw_ready), 0);
      chkv("rst_inj_ready", int'(inj_ready), 0);
      step();
      step();
      chkv("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_flit", out_flit, '0);
      chkv("rst_credits", int'(credits), 5);
      chkv("rst_overflow", int'(credit_overflow), 0);
      sw_valid = 1'b0;
      inj_valid = 1'b0;
      rst = 1'b0;
      step();

      // Five credits: five switch flits on consecutive cycles, then stall.
      for (int i = 0; i < 7; i++) begin
         sw_valid = 1'b1;
         sw_flit = in_flit(16'h5000 + sc);
         #1;
         chkv("drain_sw_ready", int'(sw_ready), int'(i < 5));
         if (i < 5) begin
            exp_q.push_back(exp_data(16'h5000 + sc));
            sc = sc + 16'd1;
         end
         step();
      end
      chkv("drain_credits", int'(credits), 0);

      // credit_in=3 at zero credits: usable next cycle, exactly three sends.
      sw_flit = in_flit(16'h5000 + sc);
      credit_in = 8'd3;
      credit_in_valid = 1'b1;
      #1;
      chkv("refill_blocked", int'(sw_ready), 0);
      step();
      credit_in_valid = 1'b0;
      credit_in = '0;
      for (int i = 0; i < 5; i++) begin
         sw_flit = in_flit(16'h5000 + sc);
         #1;
         chkv("refill_sw_ready", int'(sw_ready), int'(i < 3));
         if (i < 3) begin
            exp_q.push_back(exp_data(16'h5000 + sc));
            sc = sc + 16'd1;
         end
         step();
      end
      sw_valid = 1'b0;
      chkv("refill_credits", int'(credits), 0);

      // Both sources busy with steady credit return: I,I,I,I,S repeating.
      credit_in = 8'd5;
      credit_in_valid = 1'b1;
      step();
      credit_in = 8'd1;
      inj_valid = 1'b1;
      sw_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         sw_flit = in_flit(16'h5000 + sc);
         inj_flit = in_flit(16'h1000 + ic);
         #1;
         if ((k % 5) == 4) begin
            chkv("arb_sw_turn", int'(sw_ready), 1);
            chkv("arb_inj_wait", int'(inj_ready), 0);
            exp_q.push_back(exp_data(16'h5000 + sc));
            sc = sc + 16'd1;
         end else begin
            chkv("arb_inj_turn", int'(inj_ready), 1);
            chkv("arb_sw_wait", int'(sw_ready), 0);
            exp_q.push_back(exp_data(16'h1000 + ic));
            ic = ic + 16'd1;
         end
         step();
      end
      inj_valid = 1'b0;
      sw_valid = 1'b0;
      credit_in_valid = 1'b0;
      credit_in = '0;
      chkv("arb_credits", int'(credits), 5);

      // Down to one credit, then send coinciding with credit_in=3 gives 3.
      sw_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sw_flit = in_flit(16'h5000 + sc);
         #1;
         chkv("low_sw_ready", int'(sw_ready), 1);
         exp_q.push_back(exp_data(16'h5000 + sc));
         sc = sc + 16'd1;
         step();
      end
      chkv("low_credits_one", int'(credits), 1);
      sw_flit = in_flit(16'h5000 + sc);
      credit_in = 8'd3;
      credit_in_valid = 1'b1;
      #1;
      chkv("low_last_ready", int'(sw_ready), 1);
      exp_q.push_back(exp_data(16'h5000 + sc));
      sc = sc + 16'd1;
      step();
      sw_valid = 1'b0;
      credit_in_valid = 1'b0;
      chkv("low_credits_k", int'(credits), 3);

      // Exactly CREDIT_INIT is legal; one more sets the sticky overflow.
      credit_in = 8'd2;
      credit_in_valid = 1'b1;
      step();
      credit_in_valid = 1'b0;
      chkv("ovf_full_credits", int'(credits), 5);
      chkv("ovf_full_flag", int'(credit_overflow), 0);
      credit_in = 8'd1;
      credit_in_valid = 1'b1;
      step();
      credit_in_valid = 1'b0;
      credit_in = '0;
      chkv("ovf_clamp", int'(credits), 5);
      chkv("ovf_set", int'(credit_overflow), 1);
      step();
      step();
      step();
      chkv("ovf_sticky", int'(credit_overflow), 1);
      chkv("queue_drained", exp_q.size(), 0);

      // Reset mid-operation clears overflow and restores credits.
      sw_valid = 1'b1;
      inj_valid = 1'b1;
      rst = 1'b1;
      #1;
      chkv("rst2_sw_ready", int'(sw_ready), 0);
      chkv("rst2_inj_ready", int'(inj_ready), 0);
      chkv("rst2_overflow", int'(credit_overflow), 0);
      chkv("rst2_credits", int'(credits), 5);
      chkv("rst2_out_valid", int'(out_valid), 0);
      sw_valid = 1'b0;
      inj_valid = 1'b0;
      step();
      rst = 1'b0;
      step();

`ifdef CREDIT_RETURN_EN
      // Four consumes: credit flit(4) pre-empts the waiting switch flit.
      sw_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         sw_flit = in_flit(16'h5000 + sc);
         rx_consume = (c < 4);
         #1;
         if (c == 4) begin
            chkv("cred_preempt", int'(sw_ready), 0);
            exp_q.push_back(exp_credit(8'd4));
         end else begin
            chkv("cred_sw_ready", int'(sw_ready), 1);
            exp_q.push_back(exp_data(16'h5000 + sc));
            sc = sc + 16'd1;
         end
         step();
      end
      sw_valid = 1'b0;
      rx_consume = 1'b0;
      step();
      step();

      // One consume then idle: credit flit(1) sent 100 cycles after the pulse.
      rx_consume = 1'b1;
      step();
      rx_consume = 1'b0;
      repeat (99) step();
      exp_q.push_back(exp_credit(8'd1));
      step();
      step();
      step();
      step();
      chkv("period_queue", exp_q.size(), 0);
`else
      // rx_consume ignored: no credit flit and no pre-emption of data.
      sw_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         sw_flit = in_flit(16'h5000 + sc);
         rx_consume = (c < 4);
         #1;
         chkv("nocred_sw_ready", int'(sw_ready), 1);
         exp_q.push_back(exp_data(16'h5000 + sc));
         sc = sc + 16'd1;
         step();
      end
      sw_valid = 1'b0;
      rx_consume = 1'b0;
      repeat (110) step();
      chkv("nocred_queue", exp_q.size(), 0);
`endif

      step();
      chkv("final_queue", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
